nano_mem_arbiter: RTL
=====================

NANO_MEM_ARBITER -- requirements
Module: nano_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles waited for mem_rvalid_i after grant (2..255).
REQ-002 Port: clk_i  in  1  single clock, all state on rising edge.
REQ-003 Port: rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 Port: i_req_i  in  1  instruction-fetch request (read only).
REQ-005 Port: i_addr_i  in  32  fetch byte address.
REQ-006 Port: i_gnt_o  out  1  fetch request accepted this cycle.
REQ-007 Port: i_rvalid_o  out  1  fetch response valid, one cycle.
REQ-008 Port: i_rdata_o  out  32  fetch response data.
REQ-009 Port: d_req_i  in  1  data request.
REQ-010 Port: d_we_i  in  1  1 = store, 0 = load.
REQ-011 Port: d_be_i  in  4  byte enables.
REQ-012 Port: d_addr_i  in  32  data byte address.
REQ-013 Port: d_wdata_i  in  32  store data.
REQ-014 Port: d_gnt_o / d_rvalid_o / d_rdata_o  out  1/1/32  data grant, response valid, load data.
REQ-015 Port: err_o  out  1  pulses with the rvalid of a timed-out transaction.
REQ-016 Port: mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o[31:0], mem_wdata_o[31:0]  out  shared single-port memory request.
REQ-017 Port: mem_gnt_i  in  1  memory accepts request; mem_rvalid_i  in  1  response; mem_rdata_i  in  32  read data.

Function
REQ-018 FSM states IDLE and WAIT; one outstanding transaction maximum.
REQ-019 IDLE: mem_req_o = i_req_i | d_req_i; mem_* fields driven combinationally from the winner; fetch forces mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-020 Winner when one requester active: that requester; when both active: requester selected by round-robin pointer prio.
REQ-021 IDLE with mem_req_o=1 and mem_gnt_i=1: winner's gnt_o=1 same cycle, owner registered, prio set to the other requester, FSM -> WAIT, timeout counter cleared.
REQ-022 IDLE with mem_gnt_i=0: no gnt_o, prio unchanged, state unchanged; requesters hold req and fields stable until gnt_o.
REQ-023 WAIT: mem_req_o=0, both gnt_o=0, counter increments each cycle.
REQ-024 WAIT with mem_rvalid_i=1: owner's rvalid_o=1 and rdata_o=mem_rdata_i same cycle (stores also return rvalid), err_o=0, FSM -> IDLE.
REQ-025 WAIT with counter reaching TIMEOUT and no mem_rvalid_i: owner's rvalid_o=1, rdata_o=32'h0, err_o=1, FSM -> IDLE.
REQ-026 New grant earliest the cycle after a response (minimum 2 cycles per transaction).
REQ-027 mem_rvalid_i in IDLE ignored; no rvalid_o generated.
REQ-028 Non-owner rvalid_o held 0; rdata_o of non-owner is 32'h0.
REQ-029 Arbitration is fair: with both requesting continuously, grants alternate strictly.

Reset
REQ-030 rst_n_i low: FSM -> IDLE, prio -> data port, counter -> 0, owner -> fetch, immediately (asynchronous).
REQ-031 During reset all outputs 0: gnt_o, rvalid_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o.
REQ-032 Reset in WAIT drops the pending response; a mem_rvalid_i arriving after reset release is ignored per REQ-027.

Verification
REQ-033 Fetch only, i_addr_i=0x4, mem_gnt_i=1, mem_rdata_i=0x00500093 next cycle -> i_gnt_o cycle 0, i_rvalid_o with 0x00500093 cycle 1, err_o=0.
REQ-034 Both request at cycle 0 after reset, mem_gnt_i=1, 1-cycle memory -> d_gnt_o first, i_gnt_o at cycle 2, d_gnt_o at cycle 4 (alternating).
REQ-035 Store d_we_i=1, d_be_i=4'b0011, d_addr_i=0x10, d_wdata_i=0xCAFE -> mem_we_o=1, mem_be_o=0011, mem_addr_o=0x10, mem_wdata_o=0xCAFE; d_rvalid_o when mem_rvalid_i.
REQ-036 mem_gnt_i held 0 for 3 cycles with i_req_i=1 -> no i_gnt_o, mem_addr_o stable; grant on 4th cycle.
REQ-037 TIMEOUT=4, mem_rvalid_i never asserted -> owner rvalid_o=1, rdata_o=0, err_o=1 exactly 4 cycles after grant; FSM back in IDLE.
REQ-038 rst_n_i pulsed low in WAIT, mem_rvalid_i asserted after release -> no rvalid_o, next request arbitrated with data priority.

Source files
------------

// File: rtl/nano_mem_arbiter_if.sv
// rtl/nano_mem_arbiter_if.sv - fetch/data requester and shared-memory signals of the arbiter
// slave is the arbiter side; master is the requesters plus memory model.
interface nano_mem_arbiter_if;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;

  logic        err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/nano_mem_arbiter.sv
// rtl/nano_mem_arbiter.sv - round-robin fetch/data arbiter onto a single-port memory
// One outstanding transaction; a missing response is closed with err_o after TIMEOUT cycles.
module nano_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  nano_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner_d;
  logic       prio_d;
  logic [7:0] wait_cnt;

  logic any_req;
  logic win_d;
  logic grant;
  logic resp;

  always_comb begin
    any_req = bus.i_req_i | bus.d_req_i;
    win_d   = bus.d_req_i & (~bus.i_req_i | prio_d);
    grant   = rst_n_i && (state == IDLE) && any_req && bus.mem_gnt_i;
    resp    = rst_n_i && (state == WAIT) && (bus.mem_rvalid_i || (wait_cnt == LAST_WAIT));
  end

  // Every output is gated by rst_n_i so the bus reads all-zero while reset is held.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'h0;
    bus.mem_addr_o  = 32'h0;
    bus.mem_wdata_o = 32'h0;
    if (rst_n_i && (state == IDLE)) begin
      bus.mem_req_o = any_req;
      if (win_d) begin
        bus.mem_we_o    = bus.d_we_i;
        bus.mem_be_o    = bus.d_be_i;
        bus.mem_addr_o  = bus.d_addr_i;
        bus.mem_wdata_o = bus.d_wdata_i;
      end else if (bus.i_req_i) begin
        bus.mem_be_o   = 4'hF;
        bus.mem_addr_o = bus.i_addr_i;
      end
    end
  end

  always_comb begin
    bus.i_gnt_o    = grant & ~win_d;
    bus.d_gnt_o    = grant & win_d;
    bus.i_rvalid_o = resp & ~owner_d;
    bus.d_rvalid_o = resp & owner_d;
    bus.err_o      = resp & ~bus.mem_rvalid_i;
    bus.i_rdata_o  = 32'h0;
    bus.d_rdata_o  = 32'h0;
    if (resp && bus.mem_rvalid_i) begin
      if (owner_d) bus.d_rdata_o = bus.mem_rdata_i;
      else         bus.i_rdata_o = bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      prio_d   <= 1'b1;
      wait_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (grant) begin
        owner_d  <= win_d;
        prio_d   <= ~win_d;
        wait_cnt <= 8'd0;
        state    <= WAIT;
      end
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
      if (resp) state <= IDLE;
    end
  end

endmodule
